// File: rtl/err_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : err_accumulator
//  Purpose  : Per-channel SSE/SAE error accumulator over a fixed-length run,
//             with a 3-stage diff/metric/accumulate pipeline and saturation.
//             Optional peak |diff| tracking via ERR_ACC_MAX_TRACK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module err_accumulator #(
    parameter int INPUT_WL = 12,
    parameter int NUM_CH   = 2,
    parameter int SEQ_LEN  = 131072,
    parameter int ACC_WL   = 64
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          start,
    input  logic                          mode,
    input  logic                          in_valid,
    input  logic [NUM_CH*INPUT_WL-1:0]    data_in,
    input  logic [NUM_CH*INPUT_WL-1:0]    data_ref,
    output logic                          busy,
    output logic [NUM_CH*ACC_WL-1:0]      data_out,
    output logic                          data_valid,
    output logic [NUM_CH-1:0]             sat
`ifdef ERR_ACC_MAX_TRACK_EN
    ,
    output logic [NUM_CH*(INPUT_WL+1)-1:0] max_err
`endif
);

    localparam int          c_DIFF_WL = INPUT_WL + 1;
    localparam int          c_PROD_WL = 2 * INPUT_WL + 2;
    localparam int          c_WIDE_WL = (ACC_WL > c_PROD_WL) ? ACC_WL : c_PROD_WL;
    localparam int          c_SUM_WL  = c_WIDE_WL + 1;
    localparam logic [31:0] c_LAST    = 32'(SEQ_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_cnt;
    logic [1:0]  r_drain;
    logic        r_mode;
    logic        r_busy;
    logic        r_data_valid;
    logic        r_v1;
    logic        r_v2;

    logic        w_start_ok;
    logic        w_accept;
    logic        w_finish;

    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_accept   = (r_state == S_RUN) && in_valid;
    // Last drain cycle: the final sample has been in the accumulator for one cycle.
    assign w_finish   = (r_state == S_DRAIN) && (r_drain == 2'd2);

    assign busy       = r_busy;
    assign data_valid = r_data_valid;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_drain      <= '0;
            r_mode       <= 1'b0;
            r_busy       <= 1'b0;
            r_data_valid <= 1'b0;
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_v1         <= w_accept;
            r_v2         <= r_v1;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_mode  <= mode;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        r_cnt <= r_cnt + 32'd1;
                        if (r_cnt == c_LAST) begin
                            r_state <= S_DRAIN;
                            r_drain <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    r_drain <= r_drain + 2'd1;
                    if (w_finish) begin
                        r_state      <= S_DONE;
                        r_busy       <= 1'b0;
                        r_data_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [INPUT_WL-1:0]  w_in;
        logic [INPUT_WL-1:0]  w_ref;
        logic [c_DIFF_WL-1:0] w_diff;
        logic [c_DIFF_WL-1:0] w_abs;
        logic [c_PROD_WL-1:0] w_dx;
        logic [c_PROD_WL-1:0] w_sq;
        logic [c_PROD_WL-1:0] w_abs_ext;
        logic [c_SUM_WL-1:0]  w_sum;
        logic                 w_ovf;

        logic [c_DIFF_WL-1:0] r_diff;
        logic [c_PROD_WL-1:0] r_s2;
        logic [ACC_WL-1:0]    r_acc;
        logic [ACC_WL-1:0]    r_out;
        logic                 r_sat;

        assign w_in   = data_in [c*INPUT_WL +: INPUT_WL];
        assign w_ref  = data_ref[c*INPUT_WL +: INPUT_WL];
        assign w_diff = {w_ref[INPUT_WL-1], w_ref} - {w_in[INPUT_WL-1], w_in};

        // Magnitude of the most negative diff still fits unsigned in c_DIFF_WL bits.
        assign w_abs     = r_diff[c_DIFF_WL-1] ? (~r_diff + 1'b1) : r_diff;
        assign w_dx      = {{(c_PROD_WL-c_DIFF_WL){r_diff[c_DIFF_WL-1]}}, r_diff};
        assign w_sq      = w_dx * w_dx;
        assign w_abs_ext = {{(c_PROD_WL-c_DIFF_WL){1'b0}}, w_abs};

        assign w_sum = {{(c_SUM_WL-ACC_WL){1'b0}}, r_acc}
                     + {{(c_SUM_WL-c_PROD_WL){1'b0}}, r_s2};
        assign w_ovf = |w_sum[c_SUM_WL-1:ACC_WL];

        always_ff @(posedge clk) begin
            if (!rstn) begin
                r_diff <= '0;
                r_s2   <= '0;
                r_acc  <= '0;
                r_out  <= '0;
                r_sat  <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_diff <= w_diff;
                end
                if (r_v1) begin
                    r_s2 <= r_mode ? w_abs_ext : w_sq;
                end
                if (w_start_ok) begin
                    r_acc <= '0;
                    r_sat <= 1'b0;
                end else if (r_v2) begin
                    r_acc <= w_ovf ? {ACC_WL{1'b1}} : w_sum[ACC_WL-1:0];
                    if (w_ovf) begin
                        r_sat <= 1'b1;
                    end
                end
                if (w_finish) begin
                    r_out <= r_acc;
                end
            end
        end

        assign data_out[c*ACC_WL +: ACC_WL] = r_out;
        assign sat[c]                       = r_sat;

`ifdef ERR_ACC_MAX_TRACK_EN
        logic [c_DIFF_WL-1:0] r_peak;
        logic [c_DIFF_WL-1:0] r_max;

        always_ff @(posedge clk) begin
            if (!rstn) begin
                r_peak <= '0;
                r_max  <= '0;
            end else begin
                if (w_start_ok) begin
                    r_peak <= '0;
                end else if (r_v1 && (w_abs > r_peak)) begin
                    r_peak <= w_abs;
                end
                if (w_finish) begin
                    r_max <= r_peak;
                end
            end
        end

        assign max_err[c*c_DIFF_WL +: c_DIFF_WL] = r_max;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_err_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_err_accumulator
//  Purpose  : Self-checking bench for err_accumulator (64-bit and 8-bit
//             accumulator instances driven in lockstep).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_err_accumulator;

    localparam int INPUT_WL = 12;
    localparam int NUM_CH   = 2;
    localparam int SEQ      = 4;
    localparam int DW       = NUM_CH * INPUT_WL;
    localparam int MW       = INPUT_WL + 1;

    logic          clk      = 1'b0;
    logic          rstn     = 1'b0;
    logic          start    = 1'b0;
    logic          mode     = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] data_in  = '0;
    logic [DW-1:0] data_ref = '0;

    logic              busy_a, dv_a, busy_b, dv_b;
    logic [2*64-1:0]   out_a;
    logic [2*8-1:0]    out_b;
    logic [1:0]        sat_a, sat_b;
`ifdef ERR_ACC_MAX_TRACK_EN
    logic [2*MW-1:0]   max_a, max_b;
`endif

    logic signed [INPUT_WL-1:0] s_in  [NUM_CH][SEQ];
    logic signed [INPUT_WL-1:0] s_ref [NUM_CH][SEQ];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_pulse  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dv_a === 1'b1) n_pulse <= n_pulse + 1;
    end

    err_accumulator #(.INPUT_WL(INPUT_WL), .NUM_CH(NUM_CH), .SEQ_LEN(SEQ), .ACC_WL(64)) dut_a (
        .clk(clk), .rstn(rstn), .start(start), .mode(mode), .in_valid(in_valid),
        .data_in(data_in), .data_ref(data_ref), .busy(busy_a), .data_out(out_a),
        .data_valid(dv_a), .sat(sat_a)
`ifdef ERR_ACC_MAX_TRACK_EN
        , .max_err(max_a)
`endif
    );

    err_accumulator #(.INPUT_WL(INPUT_WL), .NUM_CH(NUM_CH), .SEQ_LEN(SEQ), .ACC_WL(8)) dut_b (
        .clk(clk), .rstn(rstn), .start(start), .mode(mode), .in_valid(in_valid),
        .data_in(data_in), .data_ref(data_ref), .busy(busy_b), .data_out(out_b),
        .data_valid(dv_b), .sat(sat_b)
`ifdef ERR_ACC_MAX_TRACK_EN
        , .max_err(max_b)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: metric per sample from plain integer arithmetic, saturating sum.
    function automatic logic [63:0] exp_sum(input int ch, input bit m, input int wl, output bit s);
        logic [64:0] cap, acc, v;
        int d;
        cap = (65'd1 << wl) - 65'd1;
        acc = '0;
        s   = 1'b0;
        for (int k = 0; k < SEQ; k++) begin
            d   = int'(s_ref[ch][k]) - int'(s_in[ch][k]);
            v   = m ? 65'((d < 0) ? -d : d) : 65'(d * d);
            acc = acc + v;
            if (acc > cap) begin
                acc = cap;
                s   = 1'b1;
            end
        end
        return acc[63:0];
    endfunction

    function automatic int exp_max(input int ch);
        int d, mx;
        mx = 0;
        for (int k = 0; k < SEQ; k++) begin
            d = int'(s_ref[ch][k]) - int'(s_in[ch][k]);
            if (d < 0) d = -d;
            if (d > mx) mx = d;
        end
        return mx;
    endfunction

    task automatic set_diffs(input int ch, input int d0, input int d1, input int d2, input int d3);
        int d [SEQ];
        int b;
        d = '{d0, d1, d2, d3};
        for (int k = 0; k < SEQ; k++) begin
            b = int'($urandom_range(0, 1000)) - 500;
            s_in[ch][k]  = INPUT_WL'(b);
            s_ref[ch][k] = INPUT_WL'(b + d[k]);
        end
    endtask

    // gap: 0 = in_valid always high, 1 = toggling 1,0,1,0, 2 = random gaps
    task automatic run_seq(input bit m, input int gap, input bit noisy);
        int              n_acc, t_acc, t_dv, ph;
        bit              v, seen, es;
        logic [63:0]     e;
        logic [2*64-1:0] exp_a;
        logic [2*8-1:0]  exp_b;
        logic [1:0]      esat_a, esat_b;
        n_acc = 0; t_acc = 0; t_dv = 0; ph = 0; seen = 1'b0;

        @(negedge clk);
        start = 1'b1; mode = m; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; mode = ~m;
        check("busy_start", busy_a, 1);
        check("sat_clr", {sat_a, sat_b}, 0);

        while (n_acc < SEQ) begin
            case (gap)
                0:       v = 1'b1;
                1:       v = (ph % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            ph++;
            in_valid = v;
            for (int c = 0; c < NUM_CH; c++) begin
                data_in [c*INPUT_WL +: INPUT_WL] = v ? s_in[c][n_acc]  : INPUT_WL'($urandom);
                data_ref[c*INPUT_WL +: INPUT_WL] = v ? s_ref[c][n_acc] : INPUT_WL'($urandom);
            end
            if (noisy) begin
                start = ($urandom_range(0, 3) == 0);
                mode  = 1'($urandom);
            end
            @(posedge clk); #1;
            if (v) begin
                n_acc++;
                t_acc = cyc;
            end
        end
        start = 1'b0;

        // Traffic after the last sample must be ignored.
        for (int i = 0; i < 20 && !seen; i++) begin
            in_valid = 1'($urandom);
            data_in  = DW'($urandom);
            data_ref = DW'($urandom);
            @(posedge clk); #1;
            if (dv_a === 1'b1) begin
                seen = 1'b1;
                t_dv = cyc;
            end
        end
        in_valid = 1'b0;

        for (int c = 0; c < NUM_CH; c++) begin
            e = exp_sum(c, m, 64, es);
            exp_a[c*64 +: 64] = e;
            esat_a[c] = es;
            e = exp_sum(c, m, 8, es);
            exp_b[c*8 +: 8] = e[7:0];
            esat_b[c] = es;
        end

        check("dv_seen", seen, 1);
        check("latency", t_dv - (t_acc - 1), 4);
        check("busy_done", {busy_a, busy_b}, 0);
        check("dv_b", dv_b, 1);
        for (int c = 0; c < NUM_CH; c++) begin
            check($sformatf("out_a_ch%0d", c), out_a[c*64 +: 64], exp_a[c*64 +: 64]);
            check($sformatf("out_b_ch%0d", c), out_b[c*8 +: 8], exp_b[c*8 +: 8]);
`ifdef ERR_ACC_MAX_TRACK_EN
            check($sformatf("max_a_ch%0d", c), max_a[c*MW +: MW], exp_max(c));
            check($sformatf("max_b_ch%0d", c), max_b[c*MW +: MW], exp_max(c));
`endif
        end
        check("sat_a", sat_a, esat_a);
        check("sat_b", sat_b, esat_b);

        @(posedge clk); #1;
        check("dv_pulse", {dv_a, dv_b}, 0);
        check("hold_a", out_a, exp_a);
        check("hold_b", out_b, exp_b);
    endtask

    initial begin
        int n0;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {busy_a, busy_b}, 0);
        check("rst_dv", {dv_a, dv_b}, 0);
        check("rst_out_a", out_a, 0);
        check("rst_out_b", out_b, 0);
        check("rst_sat", {sat_a, sat_b}, 0);
`ifdef ERR_ACC_MAX_TRACK_EN
        check("rst_max", {max_a, max_b}, 0);
`endif
        rstn = 1'b1;

        set_diffs(0, 1, -2, 3, 0);
        set_diffs(1, 5, 5, 5, 5);
        run_seq(1'b0, 0, 1'b0);
        check("sse_ch0", out_a[63:0], 14);
        check("sse_ch1", out_a[127:64], 100);
        check("sse_sat", sat_a, 0);

        run_seq(1'b1, 0, 1'b0);
        check("sae_ch0", out_a[63:0], 6);
        check("sae_ch1", out_a[127:64], 20);

        set_diffs(0, 2, 2, 2, 2);
        set_diffs(1, 2, 2, 2, 2);
        run_seq(1'b0, 1, 1'b0);
        check("gap_ch0", out_a[63:0], 16);

        set_diffs(0, 100, 100, 100, 100);
        set_diffs(1, 100, 100, 100, 100);
        run_seq(1'b0, 0, 1'b0);
        check("clamp_b", out_b[7:0], 255);
        check("clamp_sat", sat_b, 2'b11);
        check("wide_a", out_a[63:0], 40000);

        set_diffs(0, 0, 0, 0, 0);
        set_diffs(1, 0, 0, 0, 0);
        run_seq(1'b0, 0, 1'b0);
        check("sat_cleared", sat_b, 0);

        set_diffs(0, -7, 3, 5, 0);
        set_diffs(1, 1, -1, 2, -2);
        run_seq(1'b1, 2, 1'b0);
`ifdef ERR_ACC_MAX_TRACK_EN
        check("peak_ch0", max_a[MW-1:0], 7);
`endif

        // Abort a run after two accepted samples.
        n0 = n_pulse;
        @(negedge clk);
        start = 1'b1; mode = 1'b0;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1;
        data_in = DW'($urandom); data_ref = DW'($urandom);
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0; rstn = 1'b0;
        @(negedge clk);
        check("abort_busy", {busy_a, busy_b}, 0);
        check("abort_dv", {dv_a, dv_b}, 0);
        check("abort_out", out_a, 0);
        check("abort_sat", {sat_a, sat_b}, 0);
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_no_pulse", n_pulse, n0);
        set_diffs(0, 1, 1, 1, 1);
        set_diffs(1, 1, 1, 1, 1);
        run_seq(1'b0, 0, 1'b0);
        check("after_abort", out_a[63:0], 4);

        for (int r = 0; r < 40; r++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < SEQ; k++) begin
                    s_in[c][k] = INPUT_WL'($urandom);
                    if ($urandom_range(0, 1) == 1)
                        s_ref[c][k] = INPUT_WL'($urandom);
                    else
                        s_ref[c][k] = INPUT_WL'(int'(s_in[c][k]) + int'($urandom_range(0, 6)) - 3);
                end
            end
            run_seq(1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
